// File: rtl/bcd_conv_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_conv_ctrl_if
//   Request/result bundle between a producer of binary operands and the
//   sequential binary-to-BCD converter.
//
//   start    producer -> converter   request a conversion (sampled in IDLE)
//   bin_in   producer -> converter   binary operand, BIN_W bits
//   busy     converter -> producer   conversion in progress
//   done     converter -> producer   one-cycle pulse, result valid from here
//   bcd_out  converter -> producer   packed BCD, digit 0 in [3:0]
//   ovf      converter -> producer   operand did not fit in DIGITS digits
//
//   master : the side issuing conversions (testbench / upstream adder)
//   slave  : the converter itself
// ---------------------------------------------------------------------------
interface bcd_conv_ctrl_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  ovf
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output ovf
    );
endinterface

// File: rtl/bcd_conv_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_conv_ctrl
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   One shift register holds {BCD field, binary field}. Each of the BIN_W
//   iterations first corrects every BCD digit (digit >= 5 -> digit + 3) and
//   then shifts the whole register left by one. After the last shift the
//   BCD field is published together with an overflow flag that records
//   whether any 1 was shifted off the top of the BCD field.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    bcd_conv_ctrl_if.slave (start, bin_in, busy, done, bcd_out, ovf)
//
//   Timing: start accepted at edge k, done is high in the cycle after edge
//   k + 2*BIN_W; busy covers the cycles in between and drops with done.
// ---------------------------------------------------------------------------
module bcd_conv_ctrl #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_conv_ctrl_if.slave    bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CORRECT,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [SH_W-1:0]    shreg;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_acc;
    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;

    logic [BCD_W-1:0]   bcd_field;
    logic [BCD_W-1:0]   bcd_corr;
    logic               last_shift;
    logic               busy_int;
    logic               done_int;

    assign bcd_field  = shreg[SH_W-1:BIN_W];
    assign last_shift = (cnt == CNT_W'(BIN_W - 1));

    // Add-3 correction of every digit; the 4-bit sum wraps on purpose so the
    // rule stays well defined even for digit codes 10..15.
    always_comb begin
        bcd_corr = bcd_field;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_field[4*i +: 4] >= 4'd5) begin
                bcd_corr[4*i +: 4] = bcd_field[4*i +: 4] + 4'd3;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: CORRECT/SHIFT alternate until the BIN_W-th shift.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CORRECT;
            CORRECT: state_next = SHIFT;
            SHIFT:   state_next = last_shift ? DONE : CORRECT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from state only, so start/bin_in never reach
    // an output combinationally.
    always_comb begin
        busy_int = 1'b0;
        done_int = 1'b0;
        case (state)
            CORRECT, SHIFT: busy_int = 1'b1;
            DONE:           done_int = 1'b1;
            default:        ;
        endcase
    end

    // Datapath. The published result is captured on the final shift edge,
    // which is the edge that enters DONE, and then held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= {{BCD_W{1'b0}}, bus.bin_in};
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                    end
                end
                CORRECT: begin
                    shreg <= {bcd_corr, shreg[BIN_W-1:0]};
                end
                SHIFT: begin
                    shreg   <= {shreg[SH_W-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    ovf_acc <= ovf_acc | shreg[SH_W-1];
                    if (last_shift) begin
                        bcd_q <= shreg[BIN_W-1 +: BCD_W];
                        ovf_q <= ovf_acc | shreg[SH_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_int;
    assign bus.done    = done_int;
    assign bus.bcd_out = bcd_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_ctrl
//   Self-checking bench for bcd_conv_ctrl. Two instances share clk/rst_n:
//   a 3-digit converter (sel 3) and a 2-digit converter (sel 2), both with
//   an 8-bit operand. Expected BCD values come from decimal arithmetic on the
//   operand, not from any model of the shift register.
// ---------------------------------------------------------------------------
module tb_bcd_conv_ctrl;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    bcd_conv_ctrl_if #(.BIN_W(8), .DIGITS(3)) bus3 ();
    bcd_conv_ctrl_if #(.BIN_W(8), .DIGITS(2)) bus2 ();

    bcd_conv_ctrl #(.BIN_W(8), .DIGITS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    bcd_conv_ctrl #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         sel;
        logic [7:0] bin;
        logic [11:0] exp_bcd;
        logic       exp_ovf;
    } vec_t;

    // Reference: decimal digits of (value mod 10^digits), overflow when the
    // value does not fit in that many digits.
    function automatic logic [11:0] ref_bcd(input int value, input int digits);
        int lim;
        int v;
        logic [11:0] r;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        v = value % lim;
        r = '0;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int value, input int digits);
        int lim;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        return (value >= lim);
    endfunction

    function automatic logic rd_done(input int sel);
        return (sel == 2) ? bus2.done : bus3.done;
    endfunction

    function automatic logic rd_busy(input int sel);
        return (sel == 2) ? bus2.busy : bus3.busy;
    endfunction

    function automatic logic [11:0] rd_bcd(input int sel);
        return (sel == 2) ? {4'h0, bus2.bcd_out} : bus3.bcd_out;
    endfunction

    function automatic logic rd_ovf(input int sel);
        return (sel == 2) ? bus2.ovf : bus3.ovf;
    endfunction

    task automatic drive(input int sel, input logic st, input logic [7:0] bin);
        if (sel == 2) begin
            bus2.start  = st;
            bus2.bin_in = bin;
        end else begin
            bus3.start  = st;
            bus3.bin_in = bin;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One conversion, entered and left near a falling edge. start is raised
    // immediately, so calling it right after a previous conversion returns
    // gives a start in the cycle after done. latency counts rising edges
    // after the accepting edge until done is seen (-1 on timeout).
    task automatic applyStimulus(input int sel, input logic [7:0] value,
                                 output int latency, output logic [11:0] bcd,
                                 output logic ovf, output bit width_ok,
                                 output bit busy_ok, output bit hold_ok);
        int cnt;
        bit seen;
        cnt      = 0;
        seen     = 1'b0;
        busy_ok  = 1'b1;
        width_ok = 1'b0;
        hold_ok  = 1'b0;
        latency  = -1;
        bcd      = '0;
        ovf      = 1'b0;
        drive(sel, 1'b1, value);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 8'($urandom));
        while (!seen && cnt < 40) begin
            if (rd_done(sel)) begin
                seen    = 1'b1;
                latency = cnt;
                if (rd_busy(sel)) busy_ok = 1'b0;
                bcd = rd_bcd(sel);
                ovf = rd_ovf(sel);
            end else begin
                if (!rd_busy(sel)) busy_ok = 1'b0;
                @(negedge clk);
                cnt++;
            end
        end
        if (seen) begin
            @(negedge clk);
            width_ok = !rd_done(sel) && !rd_busy(sel);
            hold_ok  = (rd_bcd(sel) === bcd) && (rd_ovf(sel) === ovf);
        end
    endtask

    task automatic runAndCheck(input int sel, input logic [7:0] value,
                               input logic [11:0] exp_bcd, input logic exp_ovf,
                               input string tag);
        int lat;
        logic [11:0] bcd;
        logic ovf;
        bit width_ok, busy_ok, hold_ok;
        applyStimulus(sel, value, lat, bcd, ovf, width_ok, busy_ok, hold_ok);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd16);
        checkOutput({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        checkOutput({tag, "_done_width"}, 32'(width_ok), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy_ok), 32'd1);
        checkOutput({tag, "_hold"}, 32'(hold_ok), 32'd1);
    endtask

    initial begin
        vec_t vecs[8];
        int   n_done;
        logic [11:0] got;
        int   rv;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{sel: 3, bin: 8'd0,   exp_bcd: 12'h000, exp_ovf: 1'b0};
        vecs[1] = '{sel: 3, bin: 8'd255, exp_bcd: 12'h255, exp_ovf: 1'b0};
        vecs[2] = '{sel: 3, bin: 8'd99,  exp_bcd: 12'h099, exp_ovf: 1'b0};
        vecs[3] = '{sel: 3, bin: 8'd5,   exp_bcd: 12'h005, exp_ovf: 1'b0};
        vecs[4] = '{sel: 3, bin: 8'd128, exp_bcd: 12'h128, exp_ovf: 1'b0};
        vecs[5] = '{sel: 3, bin: 8'd201, exp_bcd: 12'h201, exp_ovf: 1'b0};
        vecs[6] = '{sel: 2, bin: 8'd200, exp_bcd: 12'h000, exp_ovf: 1'b1};
        vecs[7] = '{sel: 2, bin: 8'd99,  exp_bcd: 12'h099, exp_ovf: 1'b0};

        rst_n = 1'b0;
        drive(3, 1'b0, 8'd0);
        drive(2, 1'b0, 8'd0);
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_busy", 32'(bus3.busy), 32'd0);
        checkOutput("rst_done", 32'(bus3.done), 32'd0);
        checkOutput("rst_bcd", 32'(bus3.bcd_out), 32'd0);
        checkOutput("rst_ovf", 32'(bus3.ovf), 32'd0);
        checkOutput("rst_ovf_d2", 32'(bus2.ovf), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);

        // Directed table; consecutive entries on one instance run back-to-back.
        $display("[TB] directed vectors");
        for (int i = 0; i < 8; i++) begin
            runAndCheck(vecs[i].sel, vecs[i].bin, vecs[i].exp_bcd,
                        vecs[i].exp_ovf, $sformatf("vec%0d", i));
        end

        // start pulsed mid-conversion must be ignored.
        $display("[TB] start while busy");
        n_done = 0;
        got    = '0;
        drive(3, 1'b1, 8'd42);
        @(posedge clk);
        @(negedge clk);
        drive(3, 1'b0, 8'd42);
        repeat (4) @(negedge clk);
        drive(3, 1'b1, 8'd7);
        @(negedge clk);
        drive(3, 1'b0, 8'd7);
        for (int i = 0; i < 30; i++) begin
            if (bus3.done) begin
                n_done++;
                got = bus3.bcd_out;
            end
            @(negedge clk);
        end
        checkOutput("busy_start_done_count", 32'(n_done), 32'd1);
        checkOutput("busy_start_bcd", 32'(got), 32'h042);

        // Reset in the middle of a conversion aborts it immediately.
        $display("[TB] reset mid-conversion");
        drive(3, 1'b1, 8'd77);
        @(posedge clk);
        @(negedge clk);
        drive(3, 1'b0, 8'd77);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bus3.busy), 32'd0);
        checkOutput("abort_done", 32'(bus3.done), 32'd0);
        checkOutput("abort_bcd", 32'(bus3.bcd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus3.done) n_done++;
        end
        checkOutput("abort_no_done", 32'(n_done), 32'd0);

        // Every 8-bit operand on the 3-digit converter.
        $display("[TB] exhaustive 3-digit sweep");
        for (int v = 0; v < 256; v++) begin
            runAndCheck(3, 8'(v), ref_bcd(v, 3), ref_ovf(v, 3),
                        $sformatf("exh%0d", v));
        end

        // Random operands on the 2-digit converter, with random idle gaps.
        $display("[TB] random 2-digit operands");
        for (int i = 0; i < 40; i++) begin
            rv = int'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            runAndCheck(2, 8'(rv), ref_bcd(rv, 2), ref_ovf(rv, 2),
                        $sformatf("rnd%0d_v%0d", i, rv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
